// File: rtl/life_ctrl.sv
// Run controller for the cell-array datapath: IDLE / SEED / RUN / PAUSE / DONE sequencing.
// All outputs registered (one-cycle latency from inputs); there is no backpressure, and the FSM acts on levels every cycle.
module life_ctrl #(
  parameter int DIV_W    = 4,
  parameter int GEN_W    = 16,
  parameter int SEED_LEN = 8,
  parameter int MAX_GEN  = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             lfsr,
  input  logic             pause,
  input  logic             step,
  input  logic [DIV_W-1:0] div,
  output logic [2:0]       state,
  output logic             seed_en,
  output logic             gen_en,
  output logic [GEN_W-1:0] gen_count,
  output logic [1:0]       mode
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEED  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] MODE_IDLE  = 2'b11;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_SEED  = 2'b10;
  localparam logic [1:0] MODE_PAUSE = 2'b00;

  localparam int SEED_W = (SEED_LEN > 1) ? $clog2(SEED_LEN) : 1;
  localparam logic [SEED_W-1:0] SEED_LAST = SEED_W'(SEED_LEN - 1);
  localparam logic [GEN_W-1:0]  MAX_GEN_V = GEN_W'(MAX_GEN);

  state_e            state_q,     state_d;
  logic [DIV_W-1:0]  tick_q,      tick_d;
  logic [DIV_W-1:0]  div_q,       div_d;
  logic [SEED_W-1:0] seed_cnt_q,  seed_cnt_d;
  logic [GEN_W-1:0]  gen_count_q, gen_count_d;
  logic              step_prev_q;
  logic              gen_en_q,    gen_en_d;
  logic              seed_en_q,   seed_en_d;
  logic [1:0]        mode_q,      mode_d;

  logic              step_edge;
  logic [GEN_W-1:0]  gen_inc;
  logic              hit_max;

  assign step_edge = step & ~step_prev_q;
  assign gen_inc   = gen_count_q + GEN_W'(1);
  // MAX_GEN of 0 means free-running: the auto-stop compare is disabled.
  assign hit_max   = (MAX_GEN != 0) && (gen_inc == MAX_GEN_V);

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    div_d       = div_q;
    seed_cnt_d  = seed_cnt_q;
    gen_count_d = gen_count_q;
    gen_en_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          gen_count_d = '0;
          tick_d      = '0;
          div_d       = div;
        end else if (lfsr) begin
          state_d     = ST_SEED;
          gen_count_d = '0;
          seed_cnt_d  = '0;
        end
      end

      ST_SEED: begin
        if (seed_cnt_q == SEED_LAST) begin
          if (start) begin
            state_d = ST_RUN;
            tick_d  = '0;
            div_d   = div;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          seed_cnt_d = seed_cnt_q + SEED_W'(1);
        end
      end

      ST_RUN: begin
        if (!start) begin
          state_d = ST_IDLE;
        end else if (pause) begin
          state_d = ST_PAUSE;
        end else if (tick_q == div_q) begin
          gen_en_d    = 1'b1;
          tick_d      = '0;
          gen_count_d = gen_inc;
          if (hit_max) state_d = ST_DONE;
        end else begin
          tick_d = tick_q + DIV_W'(1);
        end
      end

      // Exits take priority, so a step edge coinciding with an exit is dropped.
      ST_PAUSE: begin
        if (!start) begin
          state_d = ST_IDLE;
        end else if (!pause) begin
          state_d = ST_RUN;
          div_d   = div;
        end else if (step_edge) begin
          gen_en_d    = 1'b1;
          gen_count_d = gen_inc;
          if (hit_max) state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (!start) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    seed_en_d = (state_d == ST_SEED);

    case (state_d)
      ST_RUN:   mode_d = MODE_RUN;
      ST_SEED:  mode_d = MODE_SEED;
      ST_PAUSE: mode_d = MODE_PAUSE;
      default:  mode_d = MODE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      div_q       <= '0;
      seed_cnt_q  <= '0;
      gen_count_q <= '0;
      step_prev_q <= 1'b0;
      gen_en_q    <= 1'b0;
      seed_en_q   <= 1'b0;
      mode_q      <= MODE_IDLE;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      div_q       <= div_d;
      seed_cnt_q  <= seed_cnt_d;
      gen_count_q <= gen_count_d;
      step_prev_q <= step;
      gen_en_q    <= gen_en_d;
      seed_en_q   <= seed_en_d;
      mode_q      <= mode_d;
    end
  end

  assign state     = state_q;
  assign seed_en   = seed_en_q;
  assign gen_en    = gen_en_q;
  assign gen_count = gen_count_q;
  assign mode      = mode_q;

endmodule

// File: tb/tb_life_ctrl.sv
// Bench for life_ctrl: directed scenarios plus randomized run against a behavioural model,
// driving one free-running instance and one with auto-stop after 3 generations.
module tb_life_ctrl;

  localparam int SEED_LEN = 8;
  localparam int ST_IDLE = 0, ST_SEED = 1, ST_RUN = 2, ST_PAUSE = 3, ST_DONE = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, lfsr = 1'b0, pause = 1'b0, step = 1'b0;
  logic [3:0]  div = 4'd0;

  logic [2:0]  s0_state, s1_state;
  logic        s0_seed, s1_seed, s0_gen_en, s1_gen_en;
  logic [15:0] s0_cnt, s1_cnt;
  logic [1:0]  s0_mode, s1_mode;

  int n_chk = 0;
  int n_pass = 0;

  life_ctrl #(.DIV_W(4), .GEN_W(16), .SEED_LEN(SEED_LEN), .MAX_GEN(0)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .lfsr(lfsr), .pause(pause), .step(step),
    .div(div), .state(s0_state), .seed_en(s0_seed), .gen_en(s0_gen_en),
    .gen_count(s0_cnt), .mode(s0_mode));

  life_ctrl #(.DIV_W(4), .GEN_W(16), .SEED_LEN(SEED_LEN), .MAX_GEN(3)) dut_mg (
    .clk(clk), .reset_n(reset_n), .start(start), .lfsr(lfsr), .pause(pause), .step(step),
    .div(div), .state(s1_state), .seed_en(s1_seed), .gen_en(s1_gen_en),
    .gen_count(s1_cnt), .mode(s1_mode));

  always #5 clk = ~clk;

  // Behavioural model: one entry per instance (index 1 stops after 3 generations).
  int m_st[2], m_tick[2], m_div[2], m_gen[2], m_ge[2], m_seed_left[2];
  int m_prev_step;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = ST_IDLE; m_tick[i] = 0; m_div[i] = 0; m_gen[i] = 0; m_ge[i] = 0; m_seed_left[i] = 0;
    end
    m_prev_step = 0;
  endtask

  task automatic model_update();
    int lim;
    bit edge_seen;
    if (!reset_n) begin
      model_reset();
      return;
    end
    edge_seen = step && (m_prev_step == 0);
    for (int i = 0; i < 2; i++) begin
      lim = (i == 1) ? 3 : 0;
      m_ge[i] = 0;
      case (m_st[i])
        ST_IDLE:
          if (start) begin m_st[i] = ST_RUN; m_gen[i] = 0; m_tick[i] = 0; m_div[i] = int'(div); end
          else if (lfsr) begin m_st[i] = ST_SEED; m_gen[i] = 0; m_seed_left[i] = SEED_LEN; end
        ST_SEED:
          if (m_seed_left[i] == 1) begin
            if (start) begin m_st[i] = ST_RUN; m_tick[i] = 0; m_div[i] = int'(div); end
            else m_st[i] = ST_IDLE;
          end else m_seed_left[i]--;
        ST_RUN:
          if (!start) m_st[i] = ST_IDLE;
          else if (pause) m_st[i] = ST_PAUSE;
          else if (m_tick[i] == m_div[i]) begin
            m_ge[i] = 1; m_tick[i] = 0; m_gen[i] = (m_gen[i] + 1) % 65536;
            if (lim != 0 && m_gen[i] == lim) m_st[i] = ST_DONE;
          end else m_tick[i] = (m_tick[i] + 1) % 16;
        ST_PAUSE:
          if (!start) m_st[i] = ST_IDLE;
          else if (!pause) begin m_st[i] = ST_RUN; m_div[i] = int'(div); end
          else if (edge_seen) begin
            m_ge[i] = 1; m_gen[i] = (m_gen[i] + 1) % 65536;
            if (lim != 0 && m_gen[i] == lim) m_st[i] = ST_DONE;
          end
        default:
          if (!start) m_st[i] = ST_IDLE;
      endcase
    end
    m_prev_step = int'(step);
  endtask

  function automatic logic [22:0] model_vec(int i);
    logic [1:0] md;
    case (m_st[i])
      ST_RUN:   md = 2'b01;
      ST_SEED:  md = 2'b10;
      ST_PAUSE: md = 2'b00;
      default:  md = 2'b11;
    endcase
    return {3'(m_st[i]), m_st[i] == ST_SEED, m_ge[i] != 0, 16'(m_gen[i]), md};
  endfunction

  task automatic tick_cyc();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 0; lfsr = 0; pause = 0; step = 0; div = 0;
    model_reset();
    repeat (2) tick_cyc();
    reset_n = 1'b1;
    repeat (5) tick_cyc();
    n_chk++; if (s0_state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", s0_state); else n_pass++;
    n_chk++; if (s0_mode !== 2'b11) $display("FAIL reset_mode: got %b expected 11", s0_mode); else n_pass++;
    n_chk++; if (s0_gen_en !== 1'b0 || s0_seed !== 1'b0) $display("FAIL reset_pulses: got gen_en=%b seed_en=%b expected 0 0", s0_gen_en, s0_seed); else n_pass++;
    n_chk++; if (s0_cnt !== 16'd0) $display("FAIL reset_count: got %0d expected 0", s0_cnt); else n_pass++;
    n_chk++; if (s1_state !== 3'd0 || s1_mode !== 2'b11) $display("FAIL reset_mg: got state=%0d mode=%b expected 0 11", s1_state, s1_mode); else n_pass++;
  endtask

  task automatic test_seed();
    int cnt;
    lfsr = 1'b1;
    tick_cyc();
    lfsr = 1'b0;
    n_chk++; if (s0_mode !== 2'b10 || s0_state !== 3'd1) $display("FAIL seed_mode: got state=%0d mode=%b expected 1 10", s0_state, s0_mode); else n_pass++;
    cnt = int'(s0_seed);
    repeat (11) begin
      tick_cyc();
      cnt += int'(s0_seed);
    end
    n_chk++; if (cnt != SEED_LEN) $display("FAIL seed_len: got %0d cycles expected %0d", cnt, SEED_LEN); else n_pass++;
    n_chk++; if (s0_state !== 3'd0 || s0_cnt !== 16'd0) $display("FAIL seed_exit: got state=%0d count=%0d expected 0 0", s0_state, s0_cnt); else n_pass++;
  endtask

  task automatic test_run();
    logic [20:1] got, exp_p;
    div = 4'd3; start = 1'b1;
    tick_cyc();
    n_chk++; if (s0_state !== 3'd2 || s0_mode !== 2'b01) $display("FAIL run_entry: got state=%0d mode=%b expected 2 01", s0_state, s0_mode); else n_pass++;
    for (int c = 1; c <= 20; c++) begin
      tick_cyc();
      got[c] = s0_gen_en;
      exp_p[c] = (c % 4 == 0);
    end
    n_chk++; if (got !== exp_p) $display("FAIL run_pulses: got %b expected %b", got, exp_p); else n_pass++;
    n_chk++; if (s0_cnt !== 16'd5) $display("FAIL run_count: got %0d expected 5", s0_cnt); else n_pass++;
  endtask

  task automatic test_pause_step();
    int n;
    start = 1'b0; tick_cyc();
    start = 1'b1; div = 4'd3; tick_cyc();
    tick_cyc(); tick_cyc();
    pause = 1'b1;
    tick_cyc();
    n_chk++; if (s0_state !== 3'd3 || s0_mode !== 2'b00 || s0_gen_en !== 1'b0) $display("FAIL pause_entry: got state=%0d mode=%b gen_en=%b expected 3 00 0", s0_state, s0_mode, s0_gen_en); else n_pass++;
    n = 0;
    repeat (6) begin tick_cyc(); n += int'(s0_gen_en); end
    n_chk++; if (n != 0) $display("FAIL pause_hold: got %0d pulses expected 0", n); else n_pass++;
    n = 0;
    repeat (3) begin
      step = 1'b1; tick_cyc(); n += int'(s0_gen_en);
      tick_cyc(); n += int'(s0_gen_en);
      step = 1'b0; tick_cyc(); n += int'(s0_gen_en);
    end
    n_chk++; if (n != 3 || s0_cnt !== 16'd3) $display("FAIL step_pulses: got pulses=%0d count=%0d expected 3 3", n, s0_cnt); else n_pass++;
    pause = 1'b0;
    tick_cyc();
    n_chk++; if (s0_state !== 3'd2 || s0_gen_en !== 1'b0) $display("FAIL resume_entry: got state=%0d gen_en=%b expected 2 0", s0_state, s0_gen_en); else n_pass++;
    tick_cyc();
    n_chk++; if (s0_gen_en !== 1'b0) $display("FAIL resume_phase1: got gen_en=%b expected 0", s0_gen_en); else n_pass++;
    tick_cyc();
    n_chk++; if (s0_gen_en !== 1'b1 || s0_cnt !== 16'd4) $display("FAIL resume_tick: got gen_en=%b count=%0d expected 1 4", s0_gen_en, s0_cnt); else n_pass++;
  endtask

  task automatic test_max_gen();
    int n;
    start = 1'b0; pause = 1'b0; tick_cyc();
    div = 4'd0; start = 1'b1; tick_cyc();
    n = 0;
    repeat (3) begin tick_cyc(); n += int'(s1_gen_en); end
    n_chk++; if (n != 3) $display("FAIL maxgen_pulses: got %0d expected 3", n); else n_pass++;
    n_chk++; if (s1_state !== 3'd4 || s1_cnt !== 16'd3) $display("FAIL maxgen_done: got state=%0d count=%0d expected 4 3", s1_state, s1_cnt); else n_pass++;
    tick_cyc();
    n_chk++; if (s1_state !== 3'd4 || s1_gen_en !== 1'b0 || s1_mode !== 2'b11) $display("FAIL done_hold: got state=%0d gen_en=%b mode=%b expected 4 0 11", s1_state, s1_gen_en, s1_mode); else n_pass++;
    n_chk++; if (s0_state !== 3'd2 || s0_cnt !== 16'd4) $display("FAIL unlimited_run: got state=%0d count=%0d expected 2 4", s0_state, s0_cnt); else n_pass++;
    start = 1'b0; tick_cyc();
    n_chk++; if (s1_state !== 3'd0 || s1_cnt !== 16'd3) $display("FAIL done_exit: got state=%0d count=%0d expected 0 3", s1_state, s1_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    start = 1'b0; tick_cyc();
    div = 4'd0; start = 1'b1; tick_cyc();
    repeat (7) tick_cyc();
    n_chk++; if (s0_cnt !== 16'd7 || s0_state !== 3'd2) $display("FAIL prereset_count: got state=%0d count=%0d expected 2 7", s0_state, s0_cnt); else n_pass++;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_chk++; if ({s0_state, s0_gen_en, s0_cnt, s0_mode} !== {3'd0, 1'b0, 16'd0, 2'b11}) $display("FAIL async_reset: got state=%0d gen_en=%b count=%0d mode=%b expected 0 0 0 11", s0_state, s0_gen_en, s0_cnt, s0_mode); else n_pass++;
    repeat (2) tick_cyc();
    reset_n = 1'b1;
    start = 1'b0; tick_cyc();
    start = 1'b1; lfsr = 1'b1;
    tick_cyc();
    lfsr = 1'b0;
    n_chk++; if (s0_state !== 3'd2 || s0_seed !== 1'b0 || s0_mode !== 2'b01) $display("FAIL start_priority: got state=%0d seed_en=%b mode=%b expected 2 0 01", s0_state, s0_seed, s0_mode); else n_pass++;
  endtask

  task automatic test_random();
    logic [22:0] act, exp_v;
    int bad = 0;
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 99) < 93);
      lfsr  = ($urandom_range(0, 99) < 25);
      if ($urandom_range(0, 99) < 12) pause = ~pause;
      step  = ($urandom_range(0, 99) < 45);
      if ($urandom_range(0, 99) < 6) div = 4'($urandom_range(0, 4));
      else if ($urandom_range(0, 99) < 1) div = 4'($urandom_range(0, 15));
      tick_cyc();
      for (int i = 0; i < 2; i++) begin
        act = (i == 0) ? {s0_state, s0_seed, s0_gen_en, s0_cnt, s0_mode}
                       : {s1_state, s1_seed, s1_gen_en, s1_cnt, s1_mode};
        exp_v = model_vec(i);
        n_chk++;
        if (act !== exp_v) begin
          if (bad < 10) $display("FAIL random_cyc%0d_inst%0d: got %h expected %h", c, i, act, exp_v);
          bad++;
        end else n_pass++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_seed();
    test_run();
    test_pause_step();
    test_max_gen();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/life_ctrl.md
Name: life_ctrl

Overview:
- Parametrised successor to the 3-state start/seed mode FSM: top-level run controller for the cell-array datapath.
- Sequences IDLE, LFSR seeding, free-running generations with a programmable tick divider, pause/single-step, and optional auto-stop after MAX_GEN generations.
- Drives seed_en to the LFSR/array loader, gen_en to the array update logic, and a 2-bit mode code to the status LEDs.

Parameters:
- DIV_W, 4, width of tick divider input div.
- GEN_W, 16, width of generation counter.
- SEED_LEN, 8, cycles seed_en is held in SEED (>=1).
- MAX_GEN, 0, auto-stop generation count; 0 = unlimited.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  run enable, level; low forces IDLE from RUN/PAUSE/DONE.
- lfsr  in  1  seed request, level, sampled in IDLE only.
- pause  in  1  pause request, level.
- step  in  1  single-step; rising edge acts in PAUSE only.
- div  in  DIV_W  tick period minus 1; captured into div_q on every entry to RUN.
- state  out  3  IDLE=0, SEED=1, RUN=2, PAUSE=3, DONE=4.
- seed_en  out  1  high throughout SEED.
- gen_en  out  1  one-cycle generation-advance pulse.
- gen_count  out  GEN_W  generations issued since last clear.
- mode  out  2  IDLE/DONE=11, RUN=01, SEED=10, PAUSE=00.

Behaviour:
- All outputs registered. reset_n low (async, any time): state=IDLE, seed_en=0, gen_en=0, gen_count=0, tick counter=0, step edge register=0, mode=11. Outputs take these values immediately, not at the next edge.
- IDLE:
  - start -> RUN; clears gen_count and tick counter. start has priority over lfsr.
  - else lfsr -> SEED; clears gen_count.
  - else hold.
- SEED:
  - seed_en=1 for exactly SEED_LEN cycles; lfsr and pause are ignored.
  - On the last cycle, go to RUN if start=1, else IDLE.
  - Next state after SEED always has seed_en=0.
- RUN:
  - Tick counter increments each cycle. When it equals div_q, the next cycle has gen_en=1, counter=0, gen_count+1 (wraps modulo 2^GEN_W).
  - First gen_en occurs div_q+1 cycles after the entry edge, then every div_q+1 cycles. div=0 gives gen_en every cycle.
  - Priority: !start -> IDLE (no gen_en, gen_count held); else pause -> PAUSE (tick suppressed, counter held); else tick.
  - If MAX_GEN!=0 and an issued tick makes gen_count==MAX_GEN -> DONE on the same edge.
- PAUSE:
  - Counter and gen_count held.
  - step rising edge (step=1, previous step=0): one gen_en pulse plus gen_count+1. MAX_GEN check applies.
  - !start -> IDLE. Else !pause -> RUN, resuming the held counter; div_q is re-captured.
  - A step edge in the same cycle as either exit is ignored.
- DONE: gen_en=0, gen_count held. !start -> IDLE.
- div changes while in RUN have no effect until the next RUN entry.
- gen_count is never cleared by IDLE itself, so the last value stays visible.
- Step edge detector runs every cycle; only PAUSE acts on it.

Test Plan:
- Reset released, start=0, lfsr=0 for 5 cycles -> state=0, mode=11, gen_en=0, gen_count=0.
- IDLE, lfsr=1 for 1 cycle, SEED_LEN=8, start=0 -> seed_en high exactly 8 cycles, mode=10, then state=0, gen_count=0.
- start=1, div=3, hold 20 cycles -> gen_en pulses at cycles 4, 8, 12, 16, 20 after entry; gen_count=5; mode=01.
- RUN div=3, pause=1 one cycle before a tick, 3 step pulses, then pause=0 -> no free tick while paused, 3 gen_en pulses on step edges, tick phase resumes from the held count.
- MAX_GEN=3, div=0, start=1 -> gen_en on 3 consecutive cycles, state=4 with gen_count=3; start=0 -> IDLE, gen_count stays 3.
- reset_n low mid-RUN (gen_count=7) -> outputs clear immediately; start=1 and lfsr=1 together in IDLE -> RUN, not SEED.
